stopwatch_lap_ctrl: RTL and testbench

Lap-time capture and recall stage between the `stopwatch` BCD counter and `sevenseg_ctrl`. Passes live time through to the display, freezes the display on a lap press while counting continues, and stores up to DEPTH lap times for later step-through recall. Lap and recall switches arrive already debounced by `chattering_cut` instances in `stopwatch_top`.

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/sw_edge_det.sv | 23 ++
 rtl/stopwatch_lap_ctrl.sv | 157 +++++++++++++++
 tb/tb_stopwatch_lap_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display path: display modes, default
// lap depth and hold duration, and the packed lap-time format.
package stopwatch_pkg;

  // Display mode encodings, also used directly as the lap controller state.
  localparam logic [1:0] MODE_LIVE   = 2'b00;
  localparam logic [1:0] MODE_HOLD   = 2'b01;
  localparam logic [1:0] MODE_RECALL = 2'b10;

  localparam int unsigned LAP_DEPTH          = 4;
  // 3 s at 32 MHz.
  localparam int unsigned HOLD_TICKS_DEFAULT = 96_000_000;

  // One lap time, most significant digit first: {10s, 1s, 100ms, 10ms}.
  typedef logic [15:0] lap_time_t;

  function automatic lap_time_t pack_time(input logic [3:0] s10, input logic [3:0] s1,
                                          input logic [3:0] ms100, input logic [3:0] ms10);
    return {s10, s1, ms100, ms10};
  endfunction

endpackage

// File: rtl/sw_edge_det.sv
// Rising-edge detector for a debounced switch level. The history register
// resets high so a switch held through reset does not register a press.
module sw_edge_det (
  input  logic clk,
  input  logic rstb,
  input  logic in_i,
  output logic rise_o
);

  logic in_q;

  // Track the previous level; synchronous active-low reset to 1.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      in_q <= 1'b1;
    end else begin
      in_q <= in_i;
    end
  end

  assign rise_o = in_i & ~in_q;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Lap capture and recall between the BCD stopwatch counter and the display.
// Passes live time through, freezes the display for a hold period on a lap
// press, stores up to DEPTH laps and steps through them on recall presses.
module stopwatch_lap_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEPTH      = LAP_DEPTH,
  parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       running_i,
  input  logic                       lap_i,
  input  logic                       recall_i,
  input  logic [3:0]                 t_10ms_i,
  input  logic [3:0]                 t_100ms_i,
  input  logic [3:0]                 t_1s_i,
  input  logic [3:0]                 t_10s_i,
  output logic [3:0]                 d_10ms_o,
  output logic [3:0]                 d_100ms_o,
  output logic [3:0]                 d_1s_o,
  output logic [3:0]                 d_10s_o,
  output logic [1:0]                 mode_o,
  output logic [$clog2(DEPTH+1)-1:0] lap_cnt_o,
  output logic                       full_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned TmrW = $clog2(HOLD_TICKS);

  logic            lap_rise, recall_rise;
  lap_time_t       live_time;
  lap_time_t       mem_q [DEPTH];
  logic            mem_we;
  logic [1:0]      state_q, state_d;
  lap_time_t       disp_q, disp_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_idx_q, rd_idx_d;
  logic [PtrW-1:0] rd_nxt;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic            full_q;

  sw_edge_det u_lap_edge (
    .clk    (clk),
    .rstb   (rstb),
    .in_i   (lap_i),
    .rise_o (lap_rise)
  );

  sw_edge_det u_recall_edge (
    .clk    (clk),
    .rstb   (rstb),
    .in_i   (recall_i),
    .rise_o (recall_rise)
  );

  assign live_time = pack_time(t_10s_i, t_1s_i, t_100ms_i, t_10ms_i);
  assign rd_nxt    = rd_idx_q + 1'b1;

  // Mode sequencing; lap presses take priority over recall presses.
  always_comb begin
    state_d  = state_q;
    disp_d   = disp_q;
    wr_ptr_d = wr_ptr_q;
    rd_idx_d = rd_idx_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    mem_we   = 1'b0;
    if (lap_rise) begin
      if (state_q == MODE_RECALL) begin
        state_d = MODE_LIVE;
        disp_d  = live_time;
      end else if (running_i) begin
        // Freeze happens even when storage is full; only the write is skipped.
        disp_d  = live_time;
        timer_d = TmrW'(HOLD_TICKS - 1);
        state_d = MODE_HOLD;
        if (!full_q) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
      end else begin
        // Lap while stopped clears the stored laps.
        cnt_d    = '0;
        wr_ptr_d = '0;
        state_d  = MODE_LIVE;
        disp_d   = live_time;
      end
    end else if (recall_rise && (state_q == MODE_RECALL)) begin
      if (CntW'(rd_idx_q) == cnt_q - 1'b1) begin
        state_d = MODE_LIVE;
        disp_d  = live_time;
      end else begin
        rd_idx_d = rd_nxt;
        disp_d   = mem_q[rd_nxt];
      end
    end else if (recall_rise && (cnt_q != '0)) begin
      rd_idx_d = '0;
      disp_d   = mem_q[0];
      state_d  = MODE_RECALL;
    end else begin
      case (state_q)
        MODE_LIVE: disp_d = live_time;
        MODE_HOLD: begin
          if (timer_q == '0) begin
            state_d = MODE_LIVE;
            disp_d  = live_time;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        MODE_RECALL: ;
        default: begin
          state_d = MODE_LIVE;
          disp_d  = live_time;
        end
      endcase
    end
  end

  // Control and display registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q  <= MODE_LIVE;
      disp_q   <= '0;
      wr_ptr_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      disp_q   <= disp_d;
      wr_ptr_q <= wr_ptr_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      full_q   <= (cnt_d == CntW'(DEPTH));
    end
  end

  // Lap storage; contents are only meaningful below cnt_q, so no reset.
  always_ff @(posedge clk) begin
    if (rstb && mem_we) begin
      mem_q[wr_ptr_q] <= live_time;
    end
  end

  assign {d_10s_o, d_1s_o, d_100ms_o, d_10ms_o} = disp_q;
  assign mode_o    = state_q;
  assign lap_cnt_o = cnt_q;
  assign full_o    = full_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Self-checking bench for stopwatch_lap_ctrl: directed scenarios followed by
// a randomized phase, all checked against a behavioural lap/recall model.
module tb_stopwatch_lap_ctrl;

  localparam int unsigned Depth = 4;
  localparam int unsigned Hold  = 16;
  localparam logic [1:0]  Live  = 2'b00;
  localparam logic [1:0]  HoldM = 2'b01;
  localparam logic [1:0]  Rcl   = 2'b10;

  logic       clk = 1'b0;
  logic       rstb, running, lap, recall;
  logic [3:0] t_10ms, t_100ms, t_1s, t_10s;
  logic [3:0] d_10ms, d_100ms, d_1s, d_10s;
  logic [1:0] mode;
  logic [2:0] lap_cnt;
  logic       full;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  logic [15:0] laps[$];
  logic [15:0] m_d;
  logic [1:0]  m_mode;
  int          m_rd, m_hold_left;
  logic        m_lap_prev, m_rec_prev;

  stopwatch_lap_ctrl #(
    .DEPTH      (Depth),
    .HOLD_TICKS (Hold)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .running_i (running),
    .lap_i     (lap),
    .recall_i  (recall),
    .t_10ms_i  (t_10ms),
    .t_100ms_i (t_100ms),
    .t_1s_i    (t_1s),
    .t_10s_i   (t_10s),
    .d_10ms_o  (d_10ms),
    .d_100ms_o (d_100ms),
    .d_1s_o    (d_1s),
    .d_10s_o   (d_10s),
    .mode_o    (mode),
    .lap_cnt_o (lap_cnt),
    .full_o    (full)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rand_bcd();
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  task automatic set_t(input logic [15:0] v);
    {t_10s, t_1s, t_100ms, t_10ms} = v;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [15:0] live;
    logic        lp, rp;
    live = {t_10s, t_1s, t_100ms, t_10ms};
    if (!rstb) begin
      laps.delete();
      m_mode = Live; m_d = '0; m_rd = 0; m_hold_left = 0;
      m_lap_prev = 1'b1; m_rec_prev = 1'b1;
      return;
    end
    lp = lap && !m_lap_prev;
    rp = recall && !m_rec_prev;
    m_lap_prev = lap;
    m_rec_prev = recall;
    if (lp) begin
      if (m_mode == Rcl) begin
        m_mode = Live; m_d = live;
      end else if (running) begin
        m_d = live;
        if (laps.size() < Depth) laps.push_back(live);
        m_hold_left = Hold;
        m_mode = HoldM;
      end else begin
        laps.delete();
        m_mode = Live; m_d = live;
      end
    end else if (rp && m_mode == Rcl) begin
      if (m_rd == laps.size() - 1) begin
        m_mode = Live; m_d = live;
      end else begin
        m_rd++; m_d = laps[m_rd];
      end
    end else if (rp && laps.size() > 0) begin
      m_rd = 0; m_d = laps[0]; m_mode = Rcl;
    end else if (m_mode == Live) begin
      m_d = live;
    end else if (m_mode == HoldM) begin
      // m_hold_left counts frozen cycles still to show, including this one.
      m_hold_left--;
      if (m_hold_left == 0) begin
        m_mode = Live; m_d = live;
      end
    end
  endtask

  task automatic step(input string tag);
    logic [21:0] got, exp;
    model_step();
    @(posedge clk);
    #1;
    got = {d_10s, d_1s, d_100ms, d_10ms, mode, lap_cnt, full};
    exp = {m_d, m_mode, 3'(laps.size()), laps.size() == Depth};
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed d=%h mode=%b cnt=%0d full=%b expected d=%h mode=%b cnt=%0d full=%b",
             tag, got[21:6], got[5:4], got[3:1], got[0], exp[21:6], exp[5:4], exp[3:1], exp[0]);
    end
  endtask

  task automatic press_lap(input string tag);
    lap = 1'b1; set_t(rand_bcd()); step(tag);
    lap = 1'b0; set_t(rand_bcd()); step(tag);
  endtask

  task automatic press_recall(input string tag);
    recall = 1'b1; set_t(rand_bcd()); step(tag);
    recall = 1'b0; set_t(rand_bcd()); step(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      set_t(rand_bcd());
      step(tag);
    end
  endtask

  initial begin
    rstb = 1'b0; running = 1'b0; lap = 1'b0; recall = 1'b0;
    set_t(16'h0000);
    m_lap_prev = 1'b1; m_rec_prev = 1'b1;
    m_mode = Live; m_d = '0; m_rd = 0; m_hold_left = 0;
    step("reset");
    set_t(16'h1234);
    step("reset_hold");

    // Live passthrough.
    rstb = 1'b1; running = 1'b1;
    set_t(16'h4321);
    step("live_first");
    idle(4, "live");

    // Single lap capture and timed hold.
    lap = 1'b1; set_t(16'h0521); step("lap_capture");
    lap = 1'b0;
    idle(Hold + 4, "hold_expire");

    // Clear, then five captures into a depth-4 store and full recall walk.
    running = 1'b0; press_lap("clear");
    running = 1'b1;
    for (int i = 0; i < 5; i++) begin
      press_lap("fill");
      idle(2, "fill_gap");
    end
    for (int i = 0; i < 5; i++) press_recall("recall_walk");
    idle(Hold, "after_walk");

    // Clear with three stored laps; following recall must be ignored.
    running = 1'b0; press_lap("clear2");
    running = 1'b1;
    for (int i = 0; i < 3; i++) press_lap("fill3");
    running = 1'b0; press_lap("clear3");
    press_recall("recall_empty");
    idle(2, "empty_live");

    // Two laps, back to LIVE, then lap and recall rise together.
    running = 1'b1;
    press_lap("two_a");
    press_lap("two_b");
    idle(Hold + 2, "two_wait");
    lap = 1'b1; recall = 1'b1; set_t(rand_bcd()); step("lap_beats_recall");
    lap = 1'b0; recall = 1'b0;
    idle(3, "lap_beats_recall_hold");

    // Reset mid-RECALL with lap held; lap still high on release.
    press_recall("pre_reset_recall");
    rstb = 1'b0; lap = 1'b1; set_t(rand_bcd()); step("reset_mid_recall");
    rstb = 1'b1;
    idle(3, "release_lap_high");
    lap = 1'b0;
    idle(2, "post_reset");

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      rstb    = ($urandom_range(0, 299) != 0);
      running = ($urandom_range(0, 7) != 0);
      lap     = ($urandom_range(0, 5) == 0);
      recall  = ($urandom_range(0, 3) == 0);
      set_t(rand_bcd());
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
